gpio_reg_arbiter: RTL and testbench

Shares the single write port of the GPIO register bank (Output[0..7], OE[0..7], LED register, addresses 0x00-0x10) between two requesters. Requester A is the I2C slave, which issues non-stallable one-cycle write strobes; these are posted into a small FIFO. Requester B is a local host/sequencer using a req/ack handshake for reads and writes. A round-robin arbiter grants one access per cycle to the bank.

---
 rtl/gpio_pkg.sv | 38 +++
 rtl/gpio_reg_arbiter_if.sv | 33 +++
 rtl/gpio_wr_fifo.sv | 72 +++++++
 rtl/gpio_reg_arbiter.sv | 141 ++++++++++++++
 tb/tb_gpio_reg_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_pkg
// Purpose  : Shared widths, register map constants, posted-write entry type
//            and arbiter FSM encoding for the GPIO register-bank arbiter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gpio_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // Register map of the GPIO bank
  localparam logic [ADDR_W-1:0] OUT_BASE = 8'h00;
  localparam logic [ADDR_W-1:0] OE_BASE  = 8'h08;
  localparam logic [ADDR_W-1:0] LED_ADDR = 8'h10;

  // LED is the last register; anything above it is an invalid access
  localparam logic [ADDR_W-1:0] MAX_ADDR = LED_ADDR;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR_A  = 2'd1,
    ST_ACK_B = 2'd2
  } state_t;

  function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
    return addr <= MAX_ADDR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : gpio_reg_arbiter_if
// Purpose  : Host (requester B) req/ack access channel to the GPIO arbiter.
// Signals  : b_req/b_we/b_addr/b_wdata  host -> arbiter, held until b_ack
//            b_ack/b_rdata/b_err        arbiter -> host, one-cycle response
// Modports : master (host side), slave (arbiter side)
// Revision : 1.0 - initial release
// ============================================================================
interface gpio_reg_arbiter_if
  import gpio_pkg::*;
  ();

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;
  logic              b_err;

  modport master (
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata, b_err
  );

  modport slave (
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata, b_err
  );

endinterface
`default_nettype wire

// File: rtl/gpio_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : gpio_wr_fifo
// Purpose  : Small synchronous FIFO for posted writes. A push while full is
//            accepted only if a pop happens in the same cycle.
// Ports    : i_clk, i_rst_n      clock, async active-low reset
//            i_push, i_wdata     write side
//            i_pop, o_rdata      read side (o_rdata = head, show-ahead)
//            o_full, o_empty     status
// Revision : 1.0 - initial release
// ============================================================================
module gpio_wr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst_n,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_wdata,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_rdata,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // The slot freed by a same-cycle pop can take the incoming word
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage needs no reset: empty/full come from the count alone
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpio_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpio_reg_arbiter
// Purpose  : Shares the GPIO register-bank write port between posted I2C
//            writes (A, buffered in a FIFO) and a req/ack host (B) using a
//            one-grant-per-cycle round-robin arbiter.
// Ports    : i_clk, i_rst_n                  clock, async active-low reset
//            i_a_wen, i_a_addr, i_a_data      I2C write strobe (no stall)
//            if_b                             host req/ack channel (slave)
//            o_reg_wen, o_reg_addr,
//            o_reg_wdata                      bank write port (registered)
//            o_reg_raddr, i_reg_rdata         bank read port (combinational)
//            o_ovf, i_ovf_clr                 sticky A-drop flag and clear
// Revision : 1.0 - initial release
// ============================================================================
module gpio_reg_arbiter
  import gpio_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  wire logic              i_clk,
  input  wire logic              i_rst_n,
  input  wire logic              i_a_wen,
  input  wire logic [ADDR_W-1:0] i_a_addr,
  input  wire logic [DATA_W-1:0] i_a_data,
  gpio_reg_arbiter_if.slave      if_b,
  output logic                   o_reg_wen,
  output logic      [ADDR_W-1:0] o_reg_addr,
  output logic      [DATA_W-1:0] o_reg_wdata,
  output logic      [ADDR_W-1:0] o_reg_raddr,
  input  wire logic [DATA_W-1:0] i_reg_rdata,
  output logic                   o_ovf,
  input  wire logic              i_ovf_clr
);

  wr_entry_t         w_push_entry;
  wr_entry_t         w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_cand_a;
  logic              w_cand_b;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_drop;
  logic              w_a_valid;
  logic              w_b_valid;

  state_t            r_state;
  logic              r_last_b;     // 1 = most recent grant went to B
  logic              r_reg_wen;
  logic [ADDR_W-1:0] r_reg_addr;
  logic [DATA_W-1:0] r_reg_wdata;
  logic              r_b_ack;
  logic [DATA_W-1:0] r_b_rdata;
  logic              r_b_err;
  logic              r_ovf;

  assign w_push_entry = '{addr: i_a_addr, data: i_a_data};

  gpio_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(wr_entry_t))
  ) u_wr_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_a_wen),
    .i_wdata (w_push_entry),
    .i_pop   (w_grant_a),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_a_valid = addr_valid(w_head.addr);
  assign w_b_valid = addr_valid(if_b.b_addr);

  // B is blocked while its Ack is on the bus so a held request is not reissued
  assign w_cand_a  = !w_empty;
  assign w_cand_b  = if_b.b_req && (r_state != ST_ACK_B);
  assign w_grant_a = w_cand_a && (!w_cand_b || r_last_b);
  assign w_grant_b = w_cand_b && !w_grant_a;
  assign w_drop    = i_a_wen && w_full && !w_grant_a;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_last_b    <= 1'b1;
      r_reg_wen   <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_b_ack     <= 1'b0;
      r_b_rdata   <= '0;
      r_b_err     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_reg_wen <= 1'b0;
      if (w_grant_a) begin
        r_state  <= ST_WR_A;
        r_last_b <= 1'b0;
        // Out-of-range posted writes are consumed but never reach the bank
        if (w_a_valid) begin
          r_reg_wen   <= 1'b1;
          r_reg_addr  <= w_head.addr;
          r_reg_wdata <= w_head.data;
        end
      end else if (w_grant_b) begin
        r_state  <= ST_ACK_B;
        r_last_b <= 1'b1;
        if (if_b.b_we && w_b_valid) begin
          r_reg_wen   <= 1'b1;
          r_reg_addr  <= if_b.b_addr;
          r_reg_wdata <= if_b.b_wdata;
        end
      end else begin
        r_state <= ST_IDLE;
      end

      r_b_ack   <= w_grant_b;
      r_b_err   <= w_grant_b && !w_b_valid;
      r_b_rdata <= (w_grant_b && !if_b.b_we && w_b_valid) ? i_reg_rdata : '0;

      // A drop wins over a coincident clear
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_reg_wen    = r_reg_wen;
  assign o_reg_addr   = r_reg_addr;
  assign o_reg_wdata  = r_reg_wdata;
  assign o_reg_raddr  = if_b.b_addr;
  assign o_ovf        = r_ovf;
  assign if_b.b_ack   = r_b_ack;
  assign if_b.b_rdata = r_b_rdata;
  assign if_b.b_err   = r_b_err;

endmodule
`default_nettype wire

// File: tb/tb_gpio_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_reg_arbiter
// Purpose  : Self-checking bench for gpio_reg_arbiter: directed scenarios
//            plus randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_reg_arbiter;
  import gpio_pkg::*;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_wen;
  logic [7:0] a_addr;
  logic [7:0] a_data;
  logic       reg_wen;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_raddr;
  logic [7:0] reg_rdata;
  logic       ovf;
  logic       ovf_clr;

  int n_checks = 0;
  int n_errors = 0;

  gpio_reg_arbiter_if bus ();

  always #5 clk = ~clk;

  // Bank read model: each register reads back its address XOR 0x58
  assign reg_rdata = reg_raddr ^ 8'h58;

  gpio_reg_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_a_wen     (a_wen),
    .i_a_addr    (a_addr),
    .i_a_data    (a_data),
    .if_b        (bus),
    .o_reg_wen   (reg_wen),
    .o_reg_addr  (reg_addr),
    .o_reg_wdata (reg_wdata),
    .o_reg_raddr (reg_raddr),
    .i_reg_rdata (reg_rdata),
    .o_ovf       (ovf),
    .i_ovf_clr   (ovf_clr)
  );

  // ---------------- reference model (transaction level) ----------------
  logic [15:0] m_q[$];
  logic        m_last_b;
  logic        exp_wen, exp_ack, exp_err, exp_ovf;
  logic [7:0]  exp_addr, exp_wdata, exp_rdata;

  always @(posedge clk or negedge rst_n) begin
    logic        ca, cb, ga, gb, n_wen, n_ovf;
    logic [7:0]  n_addr, n_wdata;
    logic [15:0] e;
    if (!rst_n) begin
      m_q.delete();
      m_last_b  <= 1'b1;
      exp_wen   <= 1'b0;
      exp_ack   <= 1'b0;
      exp_err   <= 1'b0;
      exp_ovf   <= 1'b0;
      exp_addr  <= 8'h00;
      exp_wdata <= 8'h00;
      exp_rdata <= 8'h00;
    end else begin
      ca = (m_q.size() > 0);
      cb = bus.b_req && !exp_ack;
      ga = ca && (!cb || m_last_b);
      gb = cb && !ga;
      n_wen = 1'b0;
      n_addr = exp_addr;
      n_wdata = exp_wdata;
      if (ga) begin
        e = m_q.pop_front();
        if (e[15:8] <= 8'h10) begin
          n_wen = 1'b1; n_addr = e[15:8]; n_wdata = e[7:0];
        end
      end
      if (gb && bus.b_we && bus.b_addr <= 8'h10) begin
        n_wen = 1'b1; n_addr = bus.b_addr; n_wdata = bus.b_wdata;
      end
      n_ovf = exp_ovf;
      if (a_wen && m_q.size() >= DEPTH) n_ovf = 1'b1;
      else if (ovf_clr) n_ovf = 1'b0;
      if (a_wen && m_q.size() < DEPTH) m_q.push_back({a_addr, a_data});
      if (ga) m_last_b <= 1'b0;
      else if (gb) m_last_b <= 1'b1;
      exp_wen   <= n_wen;
      exp_addr  <= n_addr;
      exp_wdata <= n_wdata;
      exp_ovf   <= n_ovf;
      exp_ack   <= gb;
      exp_err   <= gb && (bus.b_addr > 8'h10);
      exp_rdata <= (gb && !bus.b_we && bus.b_addr <= 8'h10) ? (bus.b_addr ^ 8'h58) : 8'h00;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs;
    a_wen = 1'b0; a_addr = 8'h00; a_data = 8'h00; ovf_clr = 1'b0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 8'h00; bus.b_wdata = 8'h00;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [26:0] obs;
    do_reset();
    @(negedge clk);
    obs = {reg_wen, reg_addr, reg_wdata, bus.b_ack, bus.b_err, ovf};
    n_checks++;
    if (obs !== 27'h0) begin
      n_errors++; $display("FAIL reset_state: got %h want 0", obs);
    end
    // Start a B read together with an A write, then reset mid-flight
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h02;
    a_wen = 1'b1; a_addr = 8'h03; a_data = 8'h77;
    @(posedge clk); #1;
    a_wen = 1'b0;
    n_checks++;
    if (bus.b_ack !== 1'b1) begin
      n_errors++; $display("FAIL reset_pre_ack: got %b want 1", bus.b_ack);
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {reg_wen, reg_addr, reg_wdata, bus.b_ack, bus.b_err, ovf};
    n_checks++;
    if (obs !== 27'h0 || bus.b_rdata !== 8'h00) begin
      n_errors++; $display("FAIL reset_async: got %h rdata %h want 0", obs, bus.b_rdata);
    end
    bus.b_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.b_ack !== 1'b0 || reg_wen !== 1'b0 || ovf !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_release: ack %b wen %b ovf %b want 0 0 0", bus.b_ack, reg_wen, ovf);
      end
    end
  endtask

  task automatic test_single_a;
    do_reset();
    a_wen = 1'b1; a_addr = 8'h03; a_data = 8'hA5;
    @(negedge clk);
    a_wen = 1'b0;
    n_checks++;
    if (reg_wen !== 1'b0) begin
      n_errors++; $display("FAIL single_a_early: wen %b want 0", reg_wen);
    end
    @(negedge clk);
    n_checks++;
    if ({reg_wen, reg_addr, reg_wdata} !== {1'b1, 8'h03, 8'hA5}) begin
      n_errors++; $display("FAIL single_a_write: got %b %h %h want 1 03 a5", reg_wen, reg_addr, reg_wdata);
    end
    @(negedge clk);
    n_checks++;
    if ({reg_wen, reg_addr, reg_wdata} !== {1'b0, 8'h03, 8'hA5}) begin
      n_errors++; $display("FAIL single_a_once: got %b %h %h want 0 03 a5", reg_wen, reg_addr, reg_wdata);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] seen[$];
    do_reset();
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h00;
    for (int k = 0; k < 5; k++) begin
      a_wen = 1'b1; a_addr = 8'(k); a_data = 8'hC0 + 8'(k);
      @(negedge clk);
      if (reg_wen) seen.push_back(reg_addr);
      if (k == 3) begin
        n_checks++;
        if (ovf !== 1'b0) begin
          n_errors++; $display("FAIL ovf_early: got %b want 0", ovf);
        end
      end
    end
    a_wen = 1'b0; bus.b_req = 1'b0;
    n_checks++;
    if (ovf !== 1'b1) begin
      n_errors++; $display("FAIL ovf_set: got %b want 1", ovf);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (reg_wen) seen.push_back(reg_addr);
    end
    n_checks++;
    if (seen.size() != 4 || seen[0] !== 8'h00 || seen[1] !== 8'h01 ||
        seen[2] !== 8'h02 || seen[3] !== 8'h03) begin
      n_errors++; $display("FAIL ovf_order: got %0d writes %p want 00 01 02 03", seen.size(), seen);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin
      n_errors++; $display("FAIL ovf_clr: got %b want 0", ovf);
    end
  endtask

  task automatic test_contention;
    logic exp_b;
    do_reset();
    a_wen = 1'b1; a_addr = 8'h01; a_data = 8'h11;
    @(negedge clk);
    a_wen = 1'b0;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 8'h08; bus.b_wdata = 8'hFF;
    @(negedge clk);
    n_checks++;
    if ({reg_wen, reg_addr, reg_wdata, bus.b_ack} !== {1'b1, 8'h01, 8'h11, 1'b0}) begin
      n_errors++; $display("FAIL contend_a_first: got %b %h %h ack %b want 1 01 11 ack 0",
                           reg_wen, reg_addr, reg_wdata, bus.b_ack);
    end
    @(negedge clk);
    n_checks++;
    if ({reg_wen, reg_addr, reg_wdata, bus.b_ack} !== {1'b1, 8'h08, 8'hFF, 1'b1}) begin
      n_errors++; $display("FAIL contend_b_next: got %b %h %h ack %b want 1 08 ff ack 1",
                           reg_wen, reg_addr, reg_wdata, bus.b_ack);
    end
    // Both kept pending: one idle cycle while A refills, then A,B,A,B...
    a_wen = 1'b1; a_addr = 8'h04; bus.b_addr = 8'h09;
    @(negedge clk);
    n_checks++;
    if (reg_wen !== 1'b0 || bus.b_ack !== 1'b0) begin
      n_errors++; $display("FAIL contend_gap: wen %b ack %b want 0 0", reg_wen, bus.b_ack);
    end
    for (int k = 0; k < 8; k++) begin
      a_data = 8'(k);
      @(negedge clk);
      exp_b = (k % 2) == 1;
      n_checks++;
      if (bus.b_ack !== exp_b || reg_wen !== 1'b1 || reg_addr !== (exp_b ? 8'h09 : 8'h04)) begin
        n_errors++; $display("FAIL contend_alt%0d: ack %b wen %b addr %h want ack %b wen 1",
                             k, bus.b_ack, reg_wen, reg_addr, exp_b);
      end
    end
    idle_inputs();
  endtask

  task automatic test_b_read;
    int acks;
    do_reset();
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h02;
    @(negedge clk);
    acks = int'(bus.b_ack);
    n_checks++;
    if ({bus.b_ack, bus.b_rdata, bus.b_err} !== {1'b1, 8'h5A, 1'b0}) begin
      n_errors++; $display("FAIL b_read: ack %b rdata %h err %b want 1 5a 0",
                           bus.b_ack, bus.b_rdata, bus.b_err);
    end
    // Request still held through the Ack cycle must not reissue
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      acks += int'(bus.b_ack);
      if (i == 0) bus.b_req = 1'b0;
    end
    n_checks++;
    if (acks != 1) begin
      n_errors++; $display("FAIL b_read_single_ack: got %0d acks want 1", acks);
    end
  endtask

  task automatic test_invalid;
    do_reset();
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 8'h11; bus.b_wdata = 8'h33;
    @(negedge clk);
    bus.b_req = 1'b0;
    n_checks++;
    if ({bus.b_ack, bus.b_err, reg_wen} !== 3'b110) begin
      n_errors++; $display("FAIL b_invalid: ack %b err %b wen %b want 1 1 0",
                           bus.b_ack, bus.b_err, reg_wen);
    end
    a_wen = 1'b1; a_addr = 8'h20; a_data = 8'h99;
    @(negedge clk);
    a_wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (reg_wen !== 1'b0 || reg_addr !== 8'h00 || bus.b_ack !== 1'b0) begin
        n_errors++; $display("FAIL a_invalid%0d: wen %b addr %h ack %b want 0 00 0",
                             i, reg_wen, reg_addr, bus.b_ack);
      end
    end
  endtask

  task automatic test_random;
    logic [26:0] obs, exp;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      obs = {reg_wen, reg_addr, reg_wdata, bus.b_ack, bus.b_err, ovf};
      exp = {exp_wen, exp_addr, exp_wdata, exp_ack, exp_err, exp_ovf};
      n_checks++;
      if (obs !== exp || (exp_ack && bus.b_rdata !== exp_rdata)) begin
        n_errors++; $display("FAIL random_c%0d: got %h rdata %h want %h rdata %h",
                             c, obs, bus.b_rdata, exp, exp_rdata);
      end
      // Host: finish on Ack, occasionally start a new request
      if (bus.b_req && bus.b_ack) bus.b_req = 1'b0;
      if (!bus.b_req && $urandom_range(0, 2) == 0) begin
        bus.b_req   = 1'b1;
        bus.b_we    = $urandom_range(0, 1) == 1;
        bus.b_addr  = 8'($urandom_range(0, 8'h13));
        bus.b_wdata = 8'($urandom);
      end
      a_wen   = $urandom_range(0, 1) == 1;
      a_addr  = 8'($urandom_range(0, 8'h13));
      a_data  = 8'($urandom);
      ovf_clr = $urandom_range(0, 5) == 0;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_a();
    test_overflow();
    test_contention();
    test_b_read();
    test_invalid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
